// File: rtl/memory_stage_pkg.sv
// ---------------------------------------------------------------------------
// memory_stage_pkg
// Shared types and constants for the memory-access pipeline stage.
//   state_t  : control FSM states (IDLE, REQ, RESP, DONE)
//   fault_t  : fault codes reported to writeback alongside the done strobe
//   DWORD_ALIGN_BITS : low address bits that must be zero for a doubleword
// ---------------------------------------------------------------------------
package memory_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      FAULT_NONE    = 2'b00,
      FAULT_ALIGN   = 2'b01,
      FAULT_TIMEOUT = 2'b10,
      FAULT_ILLEGAL = 2'b11
   } fault_t;

   localparam int DWORD_ALIGN_BITS = 3;

endpackage

// File: rtl/memory_access_stage_timeout.sv
// ---------------------------------------------------------------------------
// mem_timeout_counter
// Counts cycles spent waiting on the data memory and flags the last allowed
// cycle of the transaction.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count at zero (transaction start)
//   enable     : advance the count this cycle (waiting in REQ or RESP)
//   expired    : count has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module mem_timeout_counter
   import memory_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // The count saturates at LAST so it can never wrap back into range while
   // the FSM is leaving the wait states.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != LAST)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Only meaningful while the FSM is in REQ/RESP; the FSM ignores it elsewhere.
   assign expired = (count_q == LAST);

endmodule

// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
// Memory stage of the pipeline: performs one doubleword LDUR/STUR over a
// valid/ready data-memory port, resolves the branch select, and hands the
// results to writeback/fetch with a one-cycle done strobe.
//   Upstream : exValid/inReady handshake, ALUresult, writeData, PCbranch,
//              ALUzero, control_{MemRead,MemWrite,Branch,UncondBranch}
//   Results  : done, readData, aluPass, PCsrc, PCbranchOut, fault
//   Memory   : mem_req/mem_ready request handshake, mem_we, mem_addr,
//              mem_wdata; mem_rvalid/mem_rdata read response
// ---------------------------------------------------------------------------
module memory_access_stage
   import memory_stage_pkg::*;
#(
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              exValid,
   output logic              inReady,
   input  logic [DATA_W-1:0] ALUresult,
   input  logic [DATA_W-1:0] writeData,
   input  logic [DATA_W-1:0] PCbranch,
   input  logic              ALUzero,
   input  logic              control_MemRead,
   input  logic              control_MemWrite,
   input  logic              control_Branch,
   input  logic              control_UncondBranch,
   output logic              done,
   output logic [DATA_W-1:0] readData,
   output logic [DATA_W-1:0] aluPass,
   output logic              PCsrc,
   output logic [DATA_W-1:0] PCbranchOut,
   output logic [1:0]        fault,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state_q, state_d;
   fault_t            fault_q, fault_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] pcbranch_q, pcbranch_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic              we_q, we_d;
   logic              pcsrc_q, pcsrc_d;

   logic              tmo_clear;
   logic              tmo_enable;
   logic              tmo_expired;
   logic              is_mem_op;
   logic              misaligned;

   assign is_mem_op  = control_MemRead | control_MemWrite;
   assign misaligned = (ALUresult[DWORD_ALIGN_BITS-1:0] != '0);

   mem_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      fault_d     = fault_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      pcbranch_d  = pcbranch_q;
      read_data_d = read_data_q;
      we_d        = we_q;
      pcsrc_d     = pcsrc_q;
      tmo_clear   = 1'b0;
      tmo_enable  = 1'b0;

      case (state_q)
         IDLE: begin
            if (exValid) begin
               addr_d     = ALUresult;
               wdata_d    = writeData;
               pcbranch_d = PCbranch;
               we_d       = control_MemWrite;
               pcsrc_d    = control_UncondBranch | (control_Branch & ALUzero);
               // Classification order matters: an illegal read+write pair is
               // reported even when the address is also misaligned.
               if (control_MemRead && control_MemWrite) begin
                  fault_d = FAULT_ILLEGAL;
                  state_d = DONE;
               end else if (is_mem_op && misaligned) begin
                  fault_d = FAULT_ALIGN;
                  state_d = DONE;
               end else if (!is_mem_op) begin
                  fault_d = FAULT_NONE;
                  state_d = DONE;
               end else begin
                  fault_d   = FAULT_NONE;
                  state_d   = REQ;
                  tmo_clear = 1'b1;
               end
            end
         end

         REQ: begin
            tmo_enable = 1'b1;
            // A handshake in the expiry cycle still completes normally.
            if (mem_ready) begin
               state_d = we_q ? DONE : RESP;
            end else if (tmo_expired) begin
               fault_d     = FAULT_TIMEOUT;
               read_data_d = '0;
               state_d     = DONE;
            end
         end

         RESP: begin
            tmo_enable = 1'b1;
            if (mem_rvalid) begin
               read_data_d = mem_rdata;
               state_d     = DONE;
            end else if (tmo_expired) begin
               fault_d     = FAULT_TIMEOUT;
               read_data_d = '0;
               state_d     = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fault_q     <= FAULT_NONE;
         addr_q      <= '0;
         wdata_q     <= '0;
         pcbranch_q  <= '0;
         read_data_q <= '0;
         we_q        <= 1'b0;
         pcsrc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fault_q     <= fault_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         pcbranch_q  <= pcbranch_d;
         read_data_q <= read_data_d;
         we_q        <= we_d;
         pcsrc_q     <= pcsrc_d;
      end
   end

   // Handshake outputs decode straight from the state register so that an
   // asynchronous reset drops mem_req in the same instant.
   assign inReady     = (state_q == IDLE);
   assign done        = (state_q == DONE);
   assign mem_req     = (state_q == REQ);
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign readData    = read_data_q;
   assign aluPass     = addr_q;
   assign PCsrc       = pcsrc_q;
   assign PCbranchOut = pcbranch_q;
   assign fault       = fault_q;

endmodule
